el2_lsu_dccm_arb: RTL and testbench

- Arbitrates the single-ported DCCM between three requesters: the LSU load pipe (read), the store-buffer drain (write) and DMA (read or write).
- Sits between these requesters and the DCCM bank memory, and drives its wren/rden/address/data inputs.
- Grants at most one operation per cycle. Returns read valids one cycle after grant, tagged to the owning requester.
- Fixed priority, with store-buffer-full escalation and a DMA starvation counter.

---
 rtl/el2_pkg.sv | 19 +
 rtl/el2_lsu_dccm_starve_cnt.sv | 44 ++++
 rtl/el2_rvdff_sr.sv | 24 ++
 rtl/el2_lsu_dccm_arb.sv | 132 +++++++++++++
 tb/tb_el2_lsu_dccm_arb.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/el2_pkg.sv
//------------------------------------------------------------------------------
// Module      : el2_pkg
// Description : Shared types for the DCCM arbitration slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package el2_pkg;

  // Which requester owns the DCCM read data returned in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_LSU  = 2'd1,
    OWN_DMA  = 2'd2
  } el2_dccm_owner_t;

endpackage

`default_nettype wire

// File: rtl/el2_lsu_dccm_starve_cnt.sv
//------------------------------------------------------------------------------
// Module      : el2_lsu_dccm_starve_cnt
// Description : Saturating starvation counter with increment, clear and max flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module el2_lsu_dccm_starve_cnt #(
  parameter int MAX_CNT = 7,
  parameter int WIDTH   = $clog2(MAX_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt_o,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_CNT);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Clear dominates increment so a grant in the same cycle always restarts.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (inc && cnt_q != C_MAX) cnt_d = cnt_q + WIDTH'(1);
  end

  el2_rvdff_sr #(.WIDTH(WIDTH)) u_cnt_ff (
    .clk  (clk),
    .rst  (rst),
    .din  (cnt_d),
    .dout (cnt_q)
  );

  assign cnt_o  = cnt_q;
  assign at_max = (cnt_q == C_MAX);

endmodule

`default_nettype wire

// File: rtl/el2_rvdff_sr.sv
//------------------------------------------------------------------------------
// Module      : el2_rvdff_sr
// Description : Plain D flop bank with synchronous active-high reset to zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module el2_rvdff_sr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= din;
  end

endmodule

`default_nettype wire

// File: rtl/el2_lsu_dccm_arb.sv
//------------------------------------------------------------------------------
// Module      : el2_lsu_dccm_arb
// Description : Single-port DCCM arbiter for LSU load, store-buffer drain, DMA.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module el2_lsu_dccm_arb
  import el2_pkg::*;
#(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DMA_STARVE_MAX   = 7
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  lsu_rd_req,
  input  logic [DCCM_BITS-1:0]                  lsu_addr_lo,
  input  logic [DCCM_BITS-1:0]                  lsu_addr_hi,
  output logic                                  lsu_gnt,
  input  logic                                  lsu_kill,
  output logic                                  lsu_rvalid,
  input  logic                                  sb_wr_req,
  input  logic                                  sb_full,
  input  logic [DCCM_BITS-1:0]                  sb_addr_lo,
  input  logic [DCCM_BITS-1:0]                  sb_addr_hi,
  input  logic [DCCM_FDATA_WIDTH-1:0]           sb_wdata_lo,
  input  logic [DCCM_FDATA_WIDTH-1:0]           sb_wdata_hi,
  output logic                                  sb_gnt,
  input  logic                                  dma_req,
  input  logic                                  dma_write,
  input  logic [DCCM_BITS-1:0]                  dma_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0]           dma_wdata,
  output logic                                  dma_gnt,
  output logic                                  dma_rvalid,
  output logic                                  dccm_wren,
  output logic                                  dccm_rden,
  output logic [DCCM_BITS-1:0]                  dccm_wr_addr_lo,
  output logic [DCCM_BITS-1:0]                  dccm_wr_addr_hi,
  output logic [DCCM_BITS-1:0]                  dccm_rd_addr_lo,
  output logic [DCCM_BITS-1:0]                  dccm_rd_addr_hi,
  output logic [DCCM_FDATA_WIDTH-1:0]           dccm_wr_data_lo,
  output logic [DCCM_FDATA_WIDTH-1:0]           dccm_wr_data_hi,
  output logic [$clog2(DMA_STARVE_MAX+1)-1:0]   starve_cnt_o
);

  localparam int C_CNT_W = $clog2(DMA_STARVE_MAX + 1);

  logic              starve_at_max;
  logic              starve_inc;
  logic              dma_force;
  el2_dccm_owner_t   rd_owner_d;
  logic [1:0]        rd_owner_q;

  assign dma_force = dma_req & starve_at_max;

  // Grant selection and memory drive; everything stays zero while in reset.
  always_comb begin
    lsu_gnt         = 1'b0;
    sb_gnt          = 1'b0;
    dma_gnt         = 1'b0;
    dccm_wren       = 1'b0;
    dccm_rden       = 1'b0;
    dccm_wr_addr_lo = '0;
    dccm_wr_addr_hi = '0;
    dccm_rd_addr_lo = '0;
    dccm_rd_addr_hi = '0;
    dccm_wr_data_lo = '0;
    dccm_wr_data_hi = '0;
    rd_owner_d      = OWN_NONE;

    if (!rst) begin
      if (dma_force)                  dma_gnt = 1'b1;
      else if (sb_wr_req && sb_full)  sb_gnt  = 1'b1;
      else if (lsu_rd_req)            lsu_gnt = 1'b1;
      else if (sb_wr_req)             sb_gnt  = 1'b1;
      else if (dma_req)               dma_gnt = 1'b1;
    end

    if (lsu_gnt) begin
      dccm_rden       = 1'b1;
      dccm_rd_addr_lo = lsu_addr_lo;
      dccm_rd_addr_hi = lsu_addr_hi;
      rd_owner_d      = OWN_LSU;
    end else if (sb_gnt) begin
      dccm_wren       = 1'b1;
      dccm_wr_addr_lo = sb_addr_lo;
      dccm_wr_addr_hi = sb_addr_hi;
      dccm_wr_data_lo = sb_wdata_lo;
      dccm_wr_data_hi = sb_wdata_hi;
    end else if (dma_gnt && dma_write) begin
      dccm_wren       = 1'b1;
      dccm_wr_addr_lo = dma_addr;
      dccm_wr_addr_hi = dma_addr;
      dccm_wr_data_lo = dma_wdata;
      dccm_wr_data_hi = dma_wdata;
    end else if (dma_gnt) begin
      dccm_rden       = 1'b1;
      dccm_rd_addr_lo = dma_addr;
      dccm_rd_addr_hi = dma_addr;
      rd_owner_d      = OWN_DMA;
    end
  end

  el2_rvdff_sr #(.WIDTH(2)) u_rd_owner_ff (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_owner_d),
    .dout (rd_owner_q)
  );

  // Gating with rst drops data from a read granted just before reset.
  assign lsu_rvalid = ~rst & (rd_owner_q == OWN_LSU) & ~lsu_kill;
  assign dma_rvalid = ~rst & (rd_owner_q == OWN_DMA);

  assign starve_inc = dma_req & ~dma_gnt;

  el2_lsu_dccm_starve_cnt #(
    .MAX_CNT (DMA_STARVE_MAX),
    .WIDTH   (C_CNT_W)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (~starve_inc),
    .cnt_o  (starve_cnt_o),
    .at_max (starve_at_max)
  );

endmodule

`default_nettype wire

// File: tb/tb_el2_lsu_dccm_arb.sv
//------------------------------------------------------------------------------
// Module      : tb_el2_lsu_dccm_arb
// Description : Self-checking bench for el2_lsu_dccm_arb with a reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_el2_lsu_dccm_arb;

  localparam int C_AW   = 16;
  localparam int C_DW   = 39;
  localparam int C_SMAX = 7;
  localparam int C_CW   = $clog2(C_SMAX + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            lsu_rd_req, lsu_kill, sb_wr_req, sb_full, dma_req, dma_write;
  logic [C_AW-1:0] lsu_addr_lo, lsu_addr_hi, sb_addr_lo, sb_addr_hi, dma_addr;
  logic [C_DW-1:0] sb_wdata_lo, sb_wdata_hi, dma_wdata;
  logic            lsu_gnt, lsu_rvalid, sb_gnt, dma_gnt, dma_rvalid;
  logic            dccm_wren, dccm_rden;
  logic [C_AW-1:0] dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_rd_addr_lo, dccm_rd_addr_hi;
  logic [C_DW-1:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic [C_CW-1:0] starve_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference state: owner 0=none 1=lsu 2=dma; winner 0=none 1=lsu 2=sb 3=dma.
  int m_starve = 0, m_owner = 0;
  int m_starve_n = 0, m_owner_n = 0;
  int m_win = 0;

  el2_lsu_dccm_arb #(
    .DCCM_BITS        (C_AW),
    .DCCM_FDATA_WIDTH (C_DW),
    .DMA_STARVE_MAX   (C_SMAX)
  ) dut (
    .clk (clk), .rst (rst),
    .lsu_rd_req (lsu_rd_req), .lsu_addr_lo (lsu_addr_lo), .lsu_addr_hi (lsu_addr_hi),
    .lsu_gnt (lsu_gnt), .lsu_kill (lsu_kill), .lsu_rvalid (lsu_rvalid),
    .sb_wr_req (sb_wr_req), .sb_full (sb_full), .sb_addr_lo (sb_addr_lo),
    .sb_addr_hi (sb_addr_hi), .sb_wdata_lo (sb_wdata_lo), .sb_wdata_hi (sb_wdata_hi),
    .sb_gnt (sb_gnt),
    .dma_req (dma_req), .dma_write (dma_write), .dma_addr (dma_addr),
    .dma_wdata (dma_wdata), .dma_gnt (dma_gnt), .dma_rvalid (dma_rvalid),
    .dccm_wren (dccm_wren), .dccm_rden (dccm_rden),
    .dccm_wr_addr_lo (dccm_wr_addr_lo), .dccm_wr_addr_hi (dccm_wr_addr_hi),
    .dccm_rd_addr_lo (dccm_rd_addr_lo), .dccm_rd_addr_hi (dccm_rd_addr_hi),
    .dccm_wr_data_lo (dccm_wr_data_lo), .dccm_wr_data_hi (dccm_wr_data_hi),
    .starve_cnt_o (starve_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Evaluate the model against the current inputs and compare every output.
  task automatic eval();
    bit rd_l, rd_d, wr_s, wr_d;
    #1;
    if (rst)                                   m_win = 0;
    else if (dma_req && m_starve == C_SMAX)    m_win = 3;
    else if (sb_wr_req && sb_full)             m_win = 2;
    else if (lsu_rd_req)                       m_win = 1;
    else if (sb_wr_req)                        m_win = 2;
    else if (dma_req)                          m_win = 3;
    else                                       m_win = 0;
    rd_l = (m_win == 1);
    wr_s = (m_win == 2);
    rd_d = (m_win == 3) && !dma_write;
    wr_d = (m_win == 3) && dma_write;

    check("lsu_gnt", lsu_gnt, rd_l);
    check("sb_gnt",  sb_gnt,  wr_s);
    check("dma_gnt", dma_gnt, m_win == 3);
    check("rden",    dccm_rden, rd_l || rd_d);
    check("wren",    dccm_wren, wr_s || wr_d);
    check("rd_addr_lo", dccm_rd_addr_lo, rd_l ? lsu_addr_lo : rd_d ? dma_addr : '0);
    check("rd_addr_hi", dccm_rd_addr_hi, rd_l ? lsu_addr_hi : rd_d ? dma_addr : '0);
    check("wr_addr_lo", dccm_wr_addr_lo, wr_s ? sb_addr_lo : wr_d ? dma_addr : '0);
    check("wr_addr_hi", dccm_wr_addr_hi, wr_s ? sb_addr_hi : wr_d ? dma_addr : '0);
    check("wr_data_lo", dccm_wr_data_lo, wr_s ? sb_wdata_lo : wr_d ? dma_wdata : '0);
    check("wr_data_hi", dccm_wr_data_hi, wr_s ? sb_wdata_hi : wr_d ? dma_wdata : '0);
    check("lsu_rvalid", lsu_rvalid, !rst && m_owner == 1 && !lsu_kill);
    check("dma_rvalid", dma_rvalid, !rst && m_owner == 2);
    check("starve_cnt", starve_cnt_o, m_starve);

    m_owner_n  = rst ? 0 : rd_l ? 1 : rd_d ? 2 : 0;
    if (rst || !dma_req || m_win == 3) m_starve_n = 0;
    else m_starve_n = (m_starve < C_SMAX) ? m_starve + 1 : C_SMAX;
  endtask

  task automatic tick();
    @(posedge clk);
    m_owner  = m_owner_n;
    m_starve = m_starve_n;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    lsu_rd_req = 0; lsu_kill = 0; sb_wr_req = 0; sb_full = 0;
    dma_req = 0; dma_write = 0;
    lsu_addr_lo = '0; lsu_addr_hi = '0; sb_addr_lo = '0; sb_addr_hi = '0;
    dma_addr = '0; sb_wdata_lo = '0; sb_wdata_hi = '0; dma_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    // Reset with requests pending: nothing may be granted.
    lsu_rd_req = 1; sb_wr_req = 1; dma_req = 1;
    eval(); check("rst_no_gnt", {lsu_gnt, sb_gnt, dma_gnt}, 3'b000); tick();
    idle_inputs(); rst = 0;
    eval(); tick();

    // LSU-only read.
    lsu_rd_req = 1; lsu_addr_lo = 16'h0104; lsu_addr_hi = 16'h0108;
    eval();
    check("tp1_rd_lo", dccm_rd_addr_lo, 16'h0104);
    check("tp1_rd_hi", dccm_rd_addr_hi, 16'h0108);
    tick(); idle_inputs();
    eval(); check("tp1_rvalid", lsu_rvalid, 1'b1); tick();
    eval(); check("tp1_rvalid_once", lsu_rvalid, 1'b0); tick();

    // All three requesters: LSU, then sb, then DMA; counter 0,1,2,0.
    lsu_rd_req = 1; sb_wr_req = 1; dma_req = 1; sb_addr_lo = 16'h0010;
    sb_addr_hi = 16'h0014; sb_wdata_lo = 39'h1_2345_6789; sb_wdata_hi = 39'h0_ABCD_0123;
    dma_addr = 16'h0300;
    eval(); check("tp2_c0_lsu", lsu_gnt, 1'b1); check("tp2_c0_cnt", starve_cnt_o, 3'd0); tick();
    lsu_rd_req = 0;
    eval(); check("tp2_c1_sb", sb_gnt, 1'b1); check("tp2_c1_cnt", starve_cnt_o, 3'd1); tick();
    sb_wr_req = 0;
    eval(); check("tp2_c2_dma", dma_gnt, 1'b1); check("tp2_c2_cnt", starve_cnt_o, 3'd2); tick();
    dma_req = 0;
    eval(); check("tp2_c3_rv", dma_rvalid, 1'b1); check("tp2_c3_cnt", starve_cnt_o, 3'd0); tick();

    // Starvation: DMA forced through on the 8th cycle despite sb_full.
    lsu_rd_req = 1; sb_wr_req = 1; sb_full = 1; dma_req = 1;
    for (int i = 0; i < C_SMAX; i++) begin
      eval(); check("tp3_denied", dma_gnt, 1'b0); tick();
    end
    eval(); check("tp3_cnt_max", starve_cnt_o, 3'd7); check("tp3_forced", dma_gnt, 1'b1); tick();
    dma_req = 0;
    eval(); check("tp3_cnt_zero", starve_cnt_o, 3'd0); check("tp3_sb_full", sb_gnt, 1'b1); tick();

    // sb_full keeps LSU out until it drops.
    eval(); check("tp4_lsu_wait", lsu_gnt, 1'b0); tick();
    sb_full = 0;
    eval(); check("tp4_lsu_now", lsu_gnt, 1'b1); tick();
    idle_inputs();

    // Kill after grant.
    lsu_rd_req = 1; eval(); tick();
    lsu_rd_req = 0; lsu_kill = 1;
    eval(); check("tp5_kill", lsu_rvalid, 1'b0); tick();
    // kill without an owner has no effect on anything.
    eval(); tick(); lsu_kill = 0;

    // Reset right after grant.
    lsu_rd_req = 1; dma_req = 1; eval(); tick();
    lsu_rd_req = 0; rst = 1;
    eval(); check("tp6_rst_rv", lsu_rvalid, 1'b0); tick();
    rst = 0; dma_req = 0;
    eval(); check("tp6_rv_after", lsu_rvalid, 1'b0); check("tp6_cnt", starve_cnt_o, 3'd0); tick();

    // DMA write.
    dma_req = 1; dma_write = 1; dma_addr = 16'h0200; dma_wdata = 39'h7F_DEADBEEF;
    eval();
    check("tp7_wr_lo", dccm_wr_addr_lo, 16'h0200);
    check("tp7_wr_hi", dccm_wr_addr_hi, 16'h0200);
    check("tp7_data",  dccm_wr_data_hi, 39'h7F_DEADBEEF);
    check("tp7_rden",  dccm_rden, 1'b0);
    tick(); idle_inputs();
    eval(); check("tp7_no_rv", {lsu_rvalid, dma_rvalid}, 2'b00); tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 49) == 0);
      lsu_rd_req  = $urandom_range(0, 1);
      lsu_kill    = ($urandom_range(0, 5) == 0);
      sb_wr_req   = $urandom_range(0, 1);
      sb_full     = ($urandom_range(0, 3) == 0);
      dma_req     = ($urandom_range(0, 3) != 0);
      dma_write   = $urandom_range(0, 1);
      lsu_addr_lo = C_AW'($urandom); lsu_addr_hi = C_AW'($urandom);
      sb_addr_lo  = C_AW'($urandom); sb_addr_hi  = C_AW'($urandom);
      dma_addr    = C_AW'($urandom);
      sb_wdata_lo = {7'($urandom), 32'($urandom)};
      sb_wdata_hi = {7'($urandom), 32'($urandom)};
      dma_wdata   = {7'($urandom), 32'($urandom)};
      eval(); tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
